serial_subtractor8: RTL

Bit-serial two's-complement subtractor. It computes diff = a - b - bin, LSB first, one bit per clock, and produces a borrow out. It is the subtract-direction counterpart to the team's adder blocks. It trades the ripple subtractor's combinational depth for WIDTH cycles of latency, and uses a start/busy/done handshake so a controller or bench can sequence operations.

---
 rtl/serial_subtractor8_pkg.sv | 10 +
 rtl/serial_subtractor8_if.sv | 26 ++
 rtl/serial_subtractor8_full_subtractor.sv | 14 +
 rtl/serial_subtractor8.sv | 91 +++++++++
 4 files changed

// File: rtl/serial_subtractor8_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor8_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor8_if.sv
// Request/response bundle for the serial subtractor: start + operands in,
// busy/done status and the registered result out.
interface serial_subtractor8_if
  import serial_subtractor8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor8_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  // Borrow when y exceeds x, or when x==y and a borrow ripples in.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end
endmodule

// File: rtl/serial_subtractor8.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// one bit per clock, with a start/busy/done handshake.
module serial_subtractor8
  import serial_subtractor8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)(
  input logic                 clk,
  input logic                 rst,
  serial_subtractor8_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_subtractor8: WIDTH must be in 2..32");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             d_bit;
  logic             brw_nxt;

  // Single cell shared across all bit positions; operands are shifted past it.
  full_subtractor u_fs (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brw),
    .d  (d_bit),
    .bo (brw_nxt)
  );

  // Handshake FSM plus serial datapath; result registers only update on the
  // final bit so partial sums are never visible on diff/bout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            brw   <= bus.bin;
            cnt   <= '0;
            d_sh  <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= brw_nxt;
          d_sh <= {d_bit, d_sh[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff_q <= {d_bit, d_sh[WIDTH-1:1]};
            bout_q <= brw_nxt;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status decoded straight from the state register: no input-to-output path.
  always_comb begin
    bus.busy = (state == S_RUN);
    bus.done = (state == S_DONE);
    bus.diff = diff_q;
    bus.bout = bout_q;
  end

endmodule
